iob_cfg_loader: RTL and testbench
=================================

// Module: iob_cfg_loader
// PURPOSE
//  Writer side of the IO-block configuration bits: receives a serial config frame
//  and programs TSMUX[1:0] and DORREG for NUM_IOB IO blocks.
//  Sits between the bitstream source and the IO ring.
//  Outputs fan out directly to each IO block's TSMUX/DORREG inputs.
//  A frame commits atomically. A bad frame leaves the running configuration untouched.
// PARAMETERS
//  NUM_IOB    8     number of IO blocks programmed by one frame
//  SYNC_WORD  8'hA5 frame header pattern, matched MSB-first
// PORTS
//  IOCLK      in   1          single clock; all state on posedge
//  RST        in   1          asynchronous, active-high reset
//  START      in   1          begin or abort-and-restart frame reception (1-cycle pulse)
//  CFG_VALID  in   1          CFG_DATA valid this cycle
//  CFG_DATA   in   1          serial config bit
//  CFG_READY  out  1          loader accepts a bit this cycle
//  TSMUX_OUT  out  2*NUM_IOB  committed TSMUX; IOB i uses [2i+1:2i]
//  DORREG_OUT out  NUM_IOB    committed DORREG; IOB i uses bit i
//  CFG_DONE   out  1          1-cycle pulse when a frame commits
//  CFG_ERR    out  1          parity failure; held until next START or RST
// BEHAVIOUR
//  Reset (async, RST=1):
//   - TSMUX_OUT=0 (all pins tristate), DORREG_OUT=0, CFG_READY=0, CFG_DONE=0, CFG_ERR=0.
//   - State=IDLE, shadow=0, counters=0.
//  Bit acceptance: a bit is consumed only on a cycle with CFG_VALID & CFG_READY.
//   - CFG_READY=1 in HUNT, LOAD and PARITY; 0 in IDLE and COMMIT.
//  FSM (W = 3*NUM_IOB payload bits):
//   - IDLE:   START -> HUNT; clear CFG_ERR and the 8-bit sync window.
//   - HUNT:   shift each accepted bit into the sync window (sliding match).
//             When the window including the current bit == SYNC_WORD -> LOAD, bit count = 0.
//   - LOAD:   shift accepted bits into the shadow register; keep a running XOR.
//             On the W-th accepted bit -> PARITY.
//   - PARITY: consume 1 bit.
//             If running XOR ^ bit == 0 (even parity) -> COMMIT.
//             Else CFG_ERR<=1 -> IDLE; committed outputs unchanged.
//   - COMMIT: one cycle. Copy shadow to TSMUX_OUT/DORREG_OUT, CFG_DONE=1 this cycle -> IDLE.
//     Outputs therefore change exactly 1 cycle after the parity bit is accepted.
//  Payload order: IOB0 first, then IOB1, and so on. Each IOB sends 3 bits, MSB-first:
//   {TSMUX[1], TSMUX[0], DORREG}.
//  Simultaneous / boundary cases:
//   - START in any state except COMMIT: restart in HUNT; shadow and partial count discarded.
//   - START during COMMIT: the commit completes, then the loader enters HUNT next cycle.
//   - CFG_VALID=0 gaps: state and counters hold; there is no timeout.
//   - Bits arriving in IDLE: ignored (CFG_READY=0).
//   - RST mid-frame: outputs immediately return to reset values (safe tristate).
//  Width rules:
//   - Bit counter is $clog2(W+1) bits; it never wraps.
//   - Sync-window shift drops the MSB.
// STRUCTURE
//  Shared package/include:
//   - state encoding (IDLE, HUNT, LOAD, PARITY, COMMIT)
//   - SYNC_WORD default
//   - BITS_PER_IOB = 3
//   - TSMUX encodings: 00 = tristate, 01 = TS-controlled, 1x = always drive
//  One sub-module: iob_cfg_shreg (W-bit shift register with parallel output and
//   running-XOR parity). FSM and commit registers stay in the top.
// TESTING (NUM_IOB=8, W=24)
//  1 RST=1, then release
//    -> all outputs 0; bits sent with START never pulsed are ignored.
//  2 Clean frame: START, A5, payload = IOB0 {1,0,1} then 7 x {0,1,0}, even parity bit
//    -> 1 cycle after the parity bit:
//       TSMUX_OUT[1:0]=2'b10, DORREG_OUT[0]=1;
//       other IOBs TSMUX=01, DORREG=0;
//       CFG_DONE high exactly 1 cycle.
//  3 Same frame with the parity bit inverted
//    -> CFG_ERR=1, outputs keep prior values, no CFG_DONE.
//    -> Next START clears CFG_ERR.
//  4 Sync preceded by garbage 8'hD2 and the stream 1,0,1,0,0,1,0,1 with CFG_VALID gaps
//    -> lock on A5 only; the payload loads correctly.
//  5 START pulsed after 10 payload bits, then a full valid frame
//    -> only the second frame commits.
//  6 RST asserted mid-LOAD after a previous commit
//    -> outputs clear asynchronously; the loader idles until START.

Source files
------------

// File: rtl/iob_cfg_loader_pkg.sv
// iob_cfg_loader_pkg: shared types and constants for the IO-block configuration loader.
package iob_cfg_loader_pkg;
    localparam int         BITS_PER_IOB  = 3;
    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
    // TSMUX field encodings: 00 tristate, 01 TS-controlled, 1x always drive
    localparam logic [1:0] TSMUX_TRISTATE = 2'b00;
    localparam logic [1:0] TSMUX_TS_CTRL  = 2'b01;
    localparam logic [1:0] TSMUX_DRIVE    = 2'b10;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LOAD,
        ST_PARITY,
        ST_COMMIT
    } state_e;
endpackage

// File: rtl/iob_cfg_shreg.sv
// iob_cfg_shreg: W-bit serial-in shadow register with parallel output and running-XOR parity.
module iob_cfg_shreg #(
    parameter int W = 24
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o,
    output logic         par_o
);
    logic [W-1:0] q_q;
    logic         par_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q   <= '0;
            par_q <= 1'b0;
        end else if (clr_i) begin
            q_q   <= '0;
            par_q <= 1'b0;
        end else if (en_i) begin
            q_q   <= {q_q[W-2:0], d_i};
            par_q <= par_q ^ d_i;
        end
    end
    assign q_o   = q_q;
    assign par_o = par_q;
endmodule

// File: rtl/iob_cfg_loader.sv
// iob_cfg_loader: receives a serial config frame (sync, payload, even parity) and
// atomically commits TSMUX/DORREG settings for NUM_IOB IO blocks.
module iob_cfg_loader
    import iob_cfg_loader_pkg::*;
#(
    parameter int         NUM_IOB   = 8,
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic                 IOCLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 CFG_VALID,
    input  logic                 CFG_DATA,
    output logic                 CFG_READY,
    output logic [2*NUM_IOB-1:0] TSMUX_OUT,
    output logic [NUM_IOB-1:0]   DORREG_OUT,
    output logic                 CFG_DONE,
    output logic                 CFG_ERR
);
    localparam int W  = BITS_PER_IOB * NUM_IOB;
    localparam int CW = $clog2(W + 1);

    state_e               state_q, state_d;
    logic [7:0]           win_q, win_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*NUM_IOB-1:0] ts_q, ts_d;
    logic [NUM_IOB-1:0]   dor_q, dor_d;
    logic                 done_q, err_q, err_d;
    logic [W-1:0]         shadow;
    logic                 par, acc, par_ok, sync_hit;

    assign acc      = CFG_VALID & CFG_READY;
    assign par_ok   = ~(par ^ CFG_DATA);
    assign sync_hit = {win_q[6:0], CFG_DATA} == SYNC_WORD;

    iob_cfg_shreg #(.W(W)) u_shreg (
        .clk_i (IOCLK),
        .rst_i (RST),
        .clr_i (START || state_q == ST_HUNT),
        .en_i  (acc && state_q == ST_LOAD),
        .d_i   (CFG_DATA),
        .q_o   (shadow),
        .par_o (par)
    );

    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // START restarts from anywhere except COMMIT, which always finishes first
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = START ? ST_HUNT : ST_IDLE;
            ST_HUNT:   state_d = (!START && acc && sync_hit) ? ST_LOAD : ST_HUNT;
            ST_LOAD:   state_d = START ? ST_HUNT : (acc && cnt_q == CW'(W - 1)) ? ST_PARITY : ST_LOAD;
            ST_PARITY: state_d = START ? ST_HUNT : !acc ? ST_PARITY : par_ok ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: state_d = START ? ST_HUNT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        CFG_READY = state_q == ST_HUNT || state_q == ST_LOAD || state_q == ST_PARITY;
        win_d     = START ? '0 : (state_q == ST_HUNT && acc) ? {win_q[6:0], CFG_DATA} : win_q;
        cnt_d     = (START || state_q != ST_LOAD) ? '0 : cnt_q + CW'(acc);
        err_d     = START ? 1'b0 : (state_q == ST_PARITY && acc && !par_ok) ? 1'b1 : err_q;
    end

    // IOB0 arrives first, so it sits at the top of the shadow: {TSMUX[1], TSMUX[0], DORREG}
    always_comb begin
        ts_d  = '0;
        dor_d = '0;
        for (int i = 0; i < NUM_IOB; i++) begin
            ts_d[2*i +: 2] = shadow[W-1-BITS_PER_IOB*i -: 2];
            dor_d[i]       = shadow[W-3-BITS_PER_IOB*i];
        end
    end

    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            win_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            ts_q   <= {NUM_IOB{TSMUX_TRISTATE}};
            dor_q  <= '0;
        end else begin
            win_q  <= win_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            done_q <= state_q == ST_COMMIT;
            ts_q   <= (state_q == ST_COMMIT) ? ts_d : ts_q;
            dor_q  <= (state_q == ST_COMMIT) ? dor_d : dor_q;
        end
    end

    assign TSMUX_OUT  = ts_q;
    assign DORREG_OUT = dor_q;
    assign CFG_DONE   = done_q;
    assign CFG_ERR    = err_q;
endmodule

// File: tb/tb_iob_cfg_loader.sv
// tb_iob_cfg_loader: directed self-checking bench for iob_cfg_loader (NUM_IOB=8, W=24).
module tb_iob_cfg_loader;
    logic        IOCLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        CFG_VALID = 1'b0;
    logic        CFG_DATA = 1'b0;
    logic        CFG_READY, CFG_DONE, CFG_ERR;
    logic [15:0] TSMUX_OUT;
    logic [7:0]  DORREG_OUT;
    int          n_cmp = 0;
    int          n_bad = 0;

    // IOB0 {1,0,1}, IOB1..7 {0,1,0}: nine ones, parity bit 1
    localparam logic [23:0] P2    = {3'b101, {7{3'b010}}};
    // IOB0..7 = 011,100,111,000,001,110,010,101: twelve ones, parity bit 0
    localparam logic [23:0] P4    = 24'h738395;
    localparam logic [23:0] PONES = 24'hFFFFFF;

    iob_cfg_loader dut (
        .IOCLK      (IOCLK),
        .RST        (RST),
        .START      (START),
        .CFG_VALID  (CFG_VALID),
        .CFG_DATA   (CFG_DATA),
        .CFG_READY  (CFG_READY),
        .TSMUX_OUT  (TSMUX_OUT),
        .DORREG_OUT (DORREG_OUT),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR)
    );

    always #5 IOCLK = ~IOCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cyc();
        @(negedge IOCLK);
        @(posedge IOCLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        @(negedge IOCLK);
        CFG_VALID = 1'b1;
        CFG_DATA  = b;
        @(posedge IOCLK);
        #1;
        CFG_VALID = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge IOCLK);
        START = 1'b1;
        @(posedge IOCLK);
        #1;
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (gaps && (i % 2 == 0)) idle_cyc();
        end
    endtask

    task automatic send_payload(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    initial begin
        repeat (2) @(posedge IOCLK);
        #1;
        chk("rst_tsmux", 32'(TSMUX_OUT), 32'h0);
        chk("rst_dorreg", 32'(DORREG_OUT), 32'h0);
        chk("rst_ready", 32'(CFG_READY), 32'h0);
        @(negedge IOCLK);
        RST = 1'b0;
        #1;
        chk("rst_done", 32'(CFG_DONE), 32'h0);
        chk("rst_err", 32'(CFG_ERR), 32'h0);
        send_byte(8'hA5, 1'b0);
        send_payload(P2);
        send_bit(1'b1);
        idle_cyc();
        chk("nostart_tsmux", 32'(TSMUX_OUT), 32'h0);
        chk("nostart_done", 32'(CFG_DONE), 32'h0);
        chk("nostart_ready", 32'(CFG_READY), 32'h0);

        pulse_start();
        chk("hunt_ready", 32'(CFG_READY), 32'h1);
        send_byte(8'hA5, 1'b0);
        send_payload(P2);
        send_bit(1'b1);
        chk("commit_ready", 32'(CFG_READY), 32'h0);
        chk("commit_done_early", 32'(CFG_DONE), 32'h0);
        chk("commit_tsmux_early", 32'(TSMUX_OUT), 32'h0);
        idle_cyc();
        chk("clean_done", 32'(CFG_DONE), 32'h1);
        chk("clean_tsmux", 32'(TSMUX_OUT), 32'h5556);
        chk("clean_dorreg", 32'(DORREG_OUT), 32'h01);
        chk("clean_err", 32'(CFG_ERR), 32'h0);
        idle_cyc();
        chk("clean_done_pulse", 32'(CFG_DONE), 32'h0);

        pulse_start();
        send_byte(8'hA5, 1'b0);
        send_payload(PONES);
        send_bit(1'b1);
        chk("bad_err", 32'(CFG_ERR), 32'h1);
        chk("bad_ready", 32'(CFG_READY), 32'h0);
        idle_cyc();
        chk("bad_done", 32'(CFG_DONE), 32'h0);
        chk("bad_tsmux_kept", 32'(TSMUX_OUT), 32'h5556);
        chk("bad_dorreg_kept", 32'(DORREG_OUT), 32'h01);
        chk("bad_err_held", 32'(CFG_ERR), 32'h1);
        pulse_start();
        chk("start_clears_err", 32'(CFG_ERR), 32'h0);

        send_byte(8'hD2, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_payload(P4);
        send_bit(1'b0);
        chk("gap_done_early", 32'(CFG_DONE), 32'h0);
        idle_cyc();
        chk("gap_done", 32'(CFG_DONE), 32'h1);
        chk("gap_tsmux", 32'(TSMUX_OUT), 32'h9C39);
        chk("gap_dorreg", 32'(DORREG_OUT), 32'h95);

        pulse_start();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        pulse_start();
        chk("restart_done", 32'(CFG_DONE), 32'h0);
        chk("restart_tsmux_kept", 32'(TSMUX_OUT), 32'h9C39);
        send_byte(8'hA5, 1'b0);
        send_payload(P2);
        send_bit(1'b1);
        pulse_start();
        chk("restart_commit_done", 32'(CFG_DONE), 32'h1);
        chk("restart_tsmux", 32'(TSMUX_OUT), 32'h5556);
        chk("restart_dorreg", 32'(DORREG_OUT), 32'h01);
        chk("start_in_commit_hunt", 32'(CFG_READY), 32'h1);

        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge IOCLK);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_tsmux", 32'(TSMUX_OUT), 32'h0);
        chk("async_rst_dorreg", 32'(DORREG_OUT), 32'h0);
        chk("async_rst_ready", 32'(CFG_READY), 32'h0);
        idle_cyc();
        @(negedge IOCLK);
        RST = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_payload(P2);
        send_bit(1'b1);
        idle_cyc();
        chk("post_rst_idle_tsmux", 32'(TSMUX_OUT), 32'h0);
        chk("post_rst_idle_done", 32'(CFG_DONE), 32'h0);
        chk("post_rst_idle_ready", 32'(CFG_READY), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
